// File: rtl/lru_tree.sv
// Tree pseudo-LRU replacement tracker with invalid-way preference and a multi-cycle flush sweep.
// Optional read-after-write forwarding is enabled by defining LRU_TREE_BYPASS_EN.
module lru_tree #(
    parameter int ENTRIES    = 256,
    parameter int INDEX_BITS = 8,
    parameter int WAYS       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INDEX_BITS-1:0]       line_selector,
    input  logic [WAYS-1:0]             valid_mask,
    output logic [$clog2(WAYS)-1:0]     lru_way,
    input  logic                        lru_update,
    input  logic [INDEX_BITS-1:0]       update_line,
    input  logic [$clog2(WAYS)-1:0]     referenced_way,
    input  logic                        flush_req,
    output logic                        flush_busy
);

    localparam int WAY_BITS = $clog2(WAYS);
    localparam int NODES    = WAYS - 1;
    localparam int IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [INDEX_BITS:0] ENTRIES_W = (INDEX_BITS + 1)'(ENTRIES);
    localparam logic [IDX_W-1:0]    LAST_SET  = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [NODES-1:0]      tree_q [ENTRIES];

    logic                  rd_in_range, up_in_range, upd_en;
    logic [IDX_W-1:0]      rd_idx, up_idx;
    logic [NODES-1:0]      upd_bits, rd_bits;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [NODES-1:0]      wr_data;

    // Point every node on the path to 'way' away from it; off-path nodes keep their value.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                               input logic [WAY_BITS-1:0] way);
        logic [NODES-1:0]    nb;
        logic [WAY_BITS-1:0] w;
        logic [WAY_BITS-1:0] node;
        logic                b;
        nb   = bits;
        w    = way;
        node = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b        = w[WAY_BITS-1];
            nb[node] = ~b;
            node     = (node << 1) + WAY_BITS'(1) + WAY_BITS'(b);
            w        = w << 1;
        end
        return nb;
    endfunction

    function automatic logic [WAY_BITS-1:0] walk(input logic [NODES-1:0] bits);
        logic [WAY_BITS-1:0] v;
        logic [WAY_BITS-1:0] node;
        logic                b;
        v    = '0;
        node = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b    = bits[node];
            v    = (v << 1) | WAY_BITS'(b);
            node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(b);
        end
        return v;
    endfunction

    function automatic logic [WAY_BITS-1:0] first_invalid(input logic [WAYS-1:0] mask);
        logic [WAYS-1:0]     m;
        logic [WAY_BITS-1:0] v;
        logic                found;
        m     = mask;
        v     = '0;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !m[0]) begin
                found = 1'b1;
                v     = WAY_BITS'(i);
            end
            m = m >> 1;
        end
        return v;
    endfunction

    assign rd_in_range = {1'b0, line_selector} < ENTRIES_W;
    assign up_in_range = {1'b0, update_line} < ENTRIES_W;
    assign rd_idx      = line_selector[IDX_W-1:0];
    assign up_idx      = update_line[IDX_W-1:0];
    // A flush request wins over a same-cycle update, which is dropped.
    assign upd_en      = lru_update && (state_q == IDLE) && !flush_req && up_in_range;
    assign upd_bits    = up_in_range ? touch(tree_q[up_idx], referenced_way) : '0;
    assign flush_busy  = (state_q == SWEEP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_SET) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = up_idx;
        wr_data = upd_bits;
        if (state_q == SWEEP) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_data = '0;
        end else if (upd_en) begin
            wr_en = 1'b1;
        end
    end

    // During a sweep the stored bits are half-cleared, so reads see an all-zero tree.
    always_comb begin
        rd_bits = '0;
        if (rd_in_range && (state_q == IDLE)) begin
            rd_bits = tree_q[rd_idx];
        end
`ifdef LRU_TREE_BYPASS_EN
        if (upd_en && (update_line == line_selector)) begin
            rd_bits = upd_bits;
        end
`endif
        lru_way = '0;
        if (rd_in_range) begin
            if (!(&valid_mask)) begin
                lru_way = first_invalid(valid_mask);
            end else begin
                lru_way = walk(rd_bits);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tree_q[i] <= '0;
            end
        end else if (wr_en) begin
            tree_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lru_tree.sv
// Self-checking bench for lru_tree: a 4-way instance and a 2-way instance with a wider index,
// both compared against a node-array reference model addressed by level/prefix arithmetic.
module tb_lru_tree;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] ls4, ul4;
    logic [3:0] vm4;
    logic [1:0] lw4, rw4;
    logic       lu4, fr4, fb4;

    logic [8:0] ls2, ul2;
    logic [1:0] vm2;
    logic       lw2, rw2, lu2, fr2, fb2;

    int n_checks = 0;
    int n_fail   = 0;

    int mt  [256][3];
    int mt2 [256];

    lru_tree #(.ENTRIES(256), .INDEX_BITS(8), .WAYS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .line_selector(ls4), .valid_mask(vm4), .lru_way(lw4),
        .lru_update(lu4), .update_line(ul4), .referenced_way(rw4),
        .flush_req(fr4), .flush_busy(fb4)
    );

    lru_tree #(.ENTRIES(256), .INDEX_BITS(9), .WAYS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .line_selector(ls2), .valid_mask(vm2), .lru_way(lw2),
        .lru_update(lu2), .update_line(ul2), .referenced_way(rw2),
        .flush_req(fr2), .flush_busy(fb2)
    );

    // Level l node covering way prefix p sits at index (2^l - 1) + p.
    function automatic int model_victim(input int set, input int mask, input bit sweep,
                                        input bit pend, input int pw);
        int t[3];
        int v;
        if (set >= 256) return 0;
        for (int i = 0; i < 4; i++) if (((mask >> i) & 1) == 0) return i;
        if (sweep) return 0;
        for (int n = 0; n < 3; n++) t[n] = mt[set][n];
        if (pend)
            for (int l = 0; l < 2; l++) t[(1 << l) - 1 + (pw >> (2 - l))] = 1 - ((pw >> (1 - l)) & 1);
        v = 0;
        for (int l = 0; l < 2; l++) v = v * 2 + t[(1 << l) - 1 + v];
        return v;
    endfunction

    function automatic void model_touch(input int set, input int w);
        if (set >= 256) return;
        for (int l = 0; l < 2; l++) mt[set][(1 << l) - 1 + (w >> (2 - l))] = 1 - ((w >> (1 - l)) & 1);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 256; s++) begin
            for (int n = 0; n < 3; n++) mt[s][n] = 0;
            mt2[s] = 0;
        end
    endfunction

    function automatic int model2_victim(input int set, input int mask);
        if (set >= 256) return 0;
        if ((mask & 1) == 0) return 0;
        if ((mask & 2) == 0) return 1;
        return mt2[set];
    endfunction

    task automatic upd4(input int s, input int w);
        @(negedge clk);
        lu4 = 1'b1; ul4 = 8'(s); rw4 = 2'(w);
        @(posedge clk);
        model_touch(s, w);
    endtask

    task automatic upd2(input int s, input int w);
        @(negedge clk);
        lu2 = 1'b1; ul2 = 9'(s); rw2 = 1'(w);
        @(posedge clk);
        if (s < 256) mt2[s] = 1 - w;
    endtask

    task automatic test_reset();
        int sets[3];
        sets[0] = 0; sets[1] = 5; sets[2] = 255;
        rst_n = 1'b0;
        lu4 = 0; ul4 = 0; rw4 = 0; fr4 = 0; ls4 = 0; vm4 = 4'b1101;
        lu2 = 0; ul2 = 0; rw2 = 0; fr2 = 0; ls2 = 0; vm2 = 2'b11;
        model_clear();
        #3;
        n_checks++;
        if (lw4 !== 2'd1) begin n_fail++; $display("FAIL reset_invalid lru_way=%0d expected 1", lw4); end
        #20 rst_n = 1'b1;
        vm4 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ls4 = 8'(sets[i]); #1;
            n_checks++;
            if (lw4 !== 2'd0) begin n_fail++; $display("FAIL reset_way set=%0d lru_way=%0d expected 0", sets[i], lw4); end
        end
        n_checks++;
        if (fb4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy flush_busy=%0b expected 0", fb4); end
        n_checks++;
        if (lw2 !== 1'b0) begin n_fail++; $display("FAIL reset_way2 lru_way=%0d expected 0", lw2); end
    endtask

    task automatic test_access_order();
        for (int w = 0; w < 4; w++) upd4(5, w);
        @(negedge clk); lu4 = 0; ls4 = 8'd5; vm4 = 4'hF; #1;
        n_checks++;
        if (lw4 !== 2'd0 || int'(lw4) != model_victim(5, 15, 0, 0, 0)) begin
            n_fail++; $display("FAIL order_0123 lru_way=%0d expected 0", lw4);
        end
        upd4(5, 0);
        @(negedge clk); lu4 = 0; #1;
        n_checks++;
        if (lw4 !== 2'd2 || int'(lw4) != model_victim(5, 15, 0, 0, 0)) begin
            n_fail++; $display("FAIL order_then_0 lru_way=%0d expected 2", lw4);
        end
    endtask

    task automatic test_invalid_pref();
        int exp;
        @(negedge clk); ls4 = 8'd5; vm4 = 4'b1011; #1;
        n_checks++;
        if (lw4 !== 2'd2) begin n_fail++; $display("FAIL invalid_1011 lru_way=%0d expected 2", lw4); end
        vm4 = 4'b1010; #1;
        n_checks++;
        if (lw4 !== 2'd0) begin n_fail++; $display("FAIL invalid_1010 lru_way=%0d expected 0", lw4); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); ls4 = 8'($urandom); vm4 = 4'($urandom); #1;
            exp = model_victim(int'(ls4), int'(vm4), 0, 0, 0);
            n_checks++;
            if (int'(lw4) != exp) begin
                n_fail++; $display("FAIL invalid_rand set=%0d mask=%b lru_way=%0d expected %0d", ls4, vm4, lw4, exp);
            end
        end
        vm4 = 4'hF;
    endtask

    task automatic test_bypass();
        int exp_now;
        for (int w = 0; w < 4; w++) upd4(7, w);
        @(negedge clk); lu4 = 1; ul4 = 8'd7; rw4 = 2'd0; ls4 = 8'd7; vm4 = 4'hF; #1;
`ifdef LRU_TREE_BYPASS_EN
        exp_now = 2;
`else
        exp_now = 0;
`endif
        n_checks++;
        if (int'(lw4) != exp_now) begin n_fail++; $display("FAIL bypass_same_cycle lru_way=%0d expected %0d", lw4, exp_now); end
        @(posedge clk); model_touch(7, 0);
        @(negedge clk); lu4 = 0; #1;
        n_checks++;
        if (lw4 !== 2'd2) begin n_fail++; $display("FAIL bypass_next_cycle lru_way=%0d expected 2", lw4); end
    endtask

    task automatic test_back_to_back();
        int exp;
        bit pend;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            lu4 = 1'($urandom);
            ul4 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            rw4 = 2'($urandom);
            ls4 = ($urandom_range(0, 3) == 0) ? ul4 : 8'($urandom_range(0, 7));
            vm4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            #1;
`ifdef LRU_TREE_BYPASS_EN
            pend = lu4 && (ls4 == ul4);
`else
            pend = 1'b0;
`endif
            exp = model_victim(int'(ls4), int'(vm4), 0, pend, int'(rw4));
            n_checks++;
            if (int'(lw4) != exp) begin
                n_fail++; $display("FAIL rand_way cyc=%0d set=%0d mask=%b lru_way=%0d expected %0d", c, ls4, vm4, lw4, exp);
            end
            @(posedge clk);
            if (lu4) model_touch(int'(ul4), int'(rw4));
        end
        @(negedge clk); lu4 = 0; vm4 = 4'hF;
    endtask

    task automatic test_ways2();
        int exp;
        upd2(3, 1);
        @(negedge clk); lu2 = 0; ls2 = 9'd3; vm2 = 2'b11; #1;
        n_checks++;
        if (lw2 !== 1'b0) begin n_fail++; $display("FAIL w2_ref1 lru_way=%0d expected 0", lw2); end
        upd2(3, 0);
        @(negedge clk); lu2 = 0; #1;
        n_checks++;
        if (lw2 !== 1'b1) begin n_fail++; $display("FAIL w2_ref0 lru_way=%0d expected 1", lw2); end
        upd2(44, 0);
        upd2(300, 1);
        @(negedge clk); lu2 = 0; ls2 = 9'd44; #1;
        n_checks++;
        if (lw2 !== 1'b1) begin n_fail++; $display("FAIL w2_out_of_range lru_way=%0d expected 1", lw2); end
        ls2 = 9'd300; #1;
        n_checks++;
        if (lw2 !== 1'b0) begin n_fail++; $display("FAIL w2_read_oor lru_way=%0d expected 0", lw2); end
        for (int c = 0; c < 100; c++) begin
            upd2($urandom_range(0, 300), $urandom_range(0, 1));
            @(negedge clk); lu2 = 0; ls2 = 9'($urandom_range(0, 300)); vm2 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11; #1;
            exp = model2_victim(int'(ls2), int'(vm2));
            n_checks++;
            if (int'(lw2) != exp) begin n_fail++; $display("FAIL w2_rand set=%0d lru_way=%0d expected %0d", ls2, lw2, exp); end
        end
        vm2 = 2'b11;
    endtask

    task automatic test_flush();
        int  busy, exp;
        bit  done;
        for (int s = 0; s < 256; s++) upd4(s, $urandom_range(0, 3));
        // Update alongside the request must be dropped; the sweep clears everything anyway.
        @(negedge clk); lu4 = 1; ul4 = 8'd9; rw4 = 2'd0; fr4 = 1;
        @(negedge clk); lu4 = 0; fr4 = 0;
        busy = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fb4) begin
                busy++;
                lu4 = 1'($urandom); ul4 = 8'($urandom); rw4 = 2'($urandom);
                fr4 = (c == 50);
                ls4 = 8'($urandom);
                vm4 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'hF;
                #1;
                exp = model_victim(int'(ls4), int'(vm4), 1, 0, 0);
                n_checks++;
                if (int'(lw4) != exp) begin
                    n_fail++; $display("FAIL sweep_way set=%0d mask=%b lru_way=%0d expected %0d", ls4, vm4, lw4, exp);
                end
            end else begin
                done = 1; lu4 = 0; fr4 = 0;
            end
        end
        n_checks++;
        if (busy != 256) begin n_fail++; $display("FAIL flush_busy_len cycles=%0d expected 256", busy); end
        for (int s = 0; s < 256; s++) for (int n = 0; n < 3; n++) mt[s][n] = 0;
        vm4 = 4'hF;
        for (int s = 0; s < 256; s++) begin
            @(negedge clk); ls4 = 8'(s); #1;
            n_checks++;
            if (lw4 !== 2'd0) begin n_fail++; $display("FAIL post_flush set=%0d lru_way=%0d expected 0", s, lw4); end
        end

        for (int s = 200; s < 210; s++) upd4(s, $urandom_range(0, 1));
        @(negedge clk); lu4 = 0; fr4 = 1;
        @(negedge clk); fr4 = 0;
        repeat (98) @(negedge clk);
        rst_n = 1'b0; #1;
        n_checks++;
        if (fb4 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_sweep flush_busy=%0b expected 0", fb4); end
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        for (int s = 200; s < 210; s++) begin
            @(negedge clk); ls4 = 8'(s); #1;
            exp = model_victim(s, 15, 0, 0, 0);
            n_checks++;
            if (int'(lw4) != exp) begin n_fail++; $display("FAIL reset_clear set=%0d lru_way=%0d expected %0d", s, lw4, exp); end
        end
        n_checks++;
        if (fb4 !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset flush_busy=%0b expected 0", fb4); end
    endtask

    initial begin
        test_reset();
        test_access_order();
        test_invalid_pref();
        test_bypass();
        test_back_to_back();
        test_ways2();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
